// File: rtl/tt_um_yoda_uart_tx_if.sv
// Pin bundle of the Tiny Tapeout UART transmitter: dedicated inputs, outputs and bidirectional pins.
interface tt_um_yoda_uart_tx_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
    modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/tt_um_yoda_uart_tx.sv
// UART transmitter (8N1, or 8E1 when UART_TX_PARITY_EN is defined) behind the Tiny Tapeout pin set.
// uo_out = {frame count[3:0], overrun, done, busy, txd}; uio_in[0] = start, uio_in[2] = overrun clear.
module tt_um_yoda_uart_tx_core #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tt_um_yoda_uart_tx_if.slave   bus
);
    localparam logic [7:0] RELOAD = 8'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t     state_q;
    logic [7:0] div_q;
    logic [2:0] idx_q;
    logic [7:0] shift_q;
    logic       start_prev_q;
    logic       txd_q;
    logic       busy_q;
    logic       done_q;
    logic       ovr_q;
    logic [3:0] cnt_q;

    logic start_edge;
    logic bit_end;
    logic unused_uio;

    assign start_edge = bus.uio_in[0] & ~start_prev_q;
    assign bit_end    = (div_q == '0);
    assign unused_uio = &{1'b0, bus.uio_in[7:3], bus.uio_in[1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            div_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            start_prev_q <= 1'b1;
            txd_q        <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ovr_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            start_prev_q <= bus.uio_in[0];
            done_q       <= 1'b0;

            // A set request outranks a simultaneous clear.
            if (start_edge && bus.ena && (state_q != IDLE))
                ovr_q <= 1'b1;
            else if (bus.uio_in[2])
                ovr_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (start_edge && bus.ena) begin
                        shift_q <= bus.ui_in;
                        state_q <= START;
                        div_q   <= RELOAD;
                        txd_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state_q <= DATA;
                        div_q   <= RELOAD;
                        idx_q   <= '0;
                        txd_q   <= shift_q[0];
                    end else begin
                        div_q <= div_q - 8'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        div_q <= RELOAD;
                        if (idx_q == 3'd7) begin
                            idx_q <= '0;
`ifdef UART_TX_PARITY_EN
                            state_q <= PARITY;
                            txd_q   <= ^shift_q;
`else
                            state_q <= STOP;
                            txd_q   <= 1'b1;
`endif
                        end else begin
                            idx_q <= idx_q + 3'd1;
                            txd_q <= shift_q[idx_q + 3'd1];
                        end
                    end else begin
                        div_q <= div_q - 8'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state_q <= STOP;
                        div_q   <= RELOAD;
                        txd_q   <= 1'b1;
                    end else begin
                        div_q <= div_q - 8'd1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        cnt_q   <= cnt_q + 4'd1;
                        txd_q   <= 1'b1;
                    end else begin
                        div_q <= div_q - 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    txd_q   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.uo_out  = {cnt_q, ovr_q, done_q, busy_q, txd_q};
    assign bus.uio_out = '0;
    assign bus.uio_oe  = '0;
endmodule

module tt_um_yoda_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    tt_um_yoda_uart_tx_if bus ();

    assign bus.ena    = ena;
    assign bus.ui_in  = ui_in;
    assign bus.uio_in = uio_in;
    assign uo_out     = bus.uo_out;
    assign uio_out    = bus.uio_out;
    assign uio_oe     = bus.uio_oe;

    tt_um_yoda_uart_tx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );
endmodule

// File: tb/tb_tt_um_yoda_uart_tx.sv
// Directed bench for tt_um_yoda_uart_tx at CLKS_PER_BIT=16; frame length follows UART_TX_PARITY_EN.
module tb_tt_um_yoda_uart_tx;
    localparam int C = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_cnt = 0;

    tt_um_yoda_uart_tx_if bus ();

    tt_um_yoda_uart_tx #(.CLKS_PER_BIT(C)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (bus.ena),
        .ui_in   (bus.ui_in),
        .uio_in  (bus.uio_in),
        .uo_out  (bus.uo_out),
        .uio_out (bus.uio_out),
        .uio_oe  (bus.uio_oe)
    );

    always #5 clk = ~clk;

    wire       txd  = bus.uo_out[0];
    wire       busy = bus.uo_out[1];
    wire       done = bus.uo_out[2];
    wire       ovr  = bus.uo_out[3];
    wire [3:0] cnt  = bus.uo_out[7:4];

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Starts a frame at the current sample point and ends in its done cycle.
    task automatic run_frame(input logic [7:0] data, input int ovr_at, input logic [7:0] ovr_val,
                             input bit ena_drop, input bit exp_ovr);
        logic [NB-1:0] bits;
        int busy_n = 0;
        int done_n = 0;
        int bi;
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = data;
`ifdef UART_TX_PARITY_EN
        bits[9] = ^data;
`endif
        bus.ui_in  = data;
        bus.uio_in = 8'h01;
        for (int k = 1; k <= NB * C + 1; k++) begin
            @(negedge clk);
            if (k <= NB * C) begin
                bi = (k - 1) / C;
                if (((k - 1) % C == 0) || (k % C == 0))
                    check($sformatf("txd_%02h_b%0d_k%0d", data, bi, k), int'(txd), int'(bits[bi]));
            end
            busy_n += int'(busy);
            done_n += int'(done);
            if (k == NB * C + 1) begin
                check("done_cycle_done", int'(done), 1);
                check("done_cycle_txd", int'(txd), 1);
                check("done_cycle_cnt", int'(cnt), (exp_cnt + 1) % 16);
            end
            if (k == 1) begin
                bus.uio_in = 8'h00;
                bus.ui_in  = ~data;
            end
            if (k == ovr_at)     bus.uio_in = ovr_val;
            if (k == ovr_at + 1) bus.uio_in = 8'h00;
            if (ena_drop && k == 30)     bus.ena = 1'b0;
            if (ena_drop && k == NB * C) bus.ena = 1'b1;
        end
        exp_cnt++;
        check("busy_cycles", busy_n, NB * C);
        check("done_pulses", done_n, 1);
        check("overrun_after_frame", int'(ovr), int'(exp_ovr));
    endtask

    task automatic clear_overrun();
        bus.uio_in = 8'h04;
        @(negedge clk);
        bus.uio_in = 8'h00;
        @(negedge clk);
        check("overrun_cleared", int'(ovr), 0);
    endtask

    initial begin
        int busy_n;
        int done_n;
        rst_n      = 1'b0;
        bus.ena    = 1'b1;
        bus.ui_in  = 8'h00;
        bus.uio_in = 8'h01;
        repeat (3) @(negedge clk);
        check("reset_uo_out", int'(bus.uo_out), 8'h01);
        check("reset_uio_out", int'(bus.uio_out), 0);
        check("reset_uio_oe", int'(bus.uio_oe), 0);

        // Start held high across reset release must not launch a frame.
        rst_n = 1'b1;
        busy_n = 0;
        repeat (6) begin
            @(negedge clk);
            busy_n += int'(busy);
        end
        check("start_held_through_reset", busy_n, 0);
        bus.uio_in = 8'h00;
        repeat (3) @(negedge clk);

        run_frame(8'hA5, 0, 8'h00, 1'b0, 1'b0);
        check("count_after_first", int'(cnt), 1);
        repeat (4) @(negedge clk);
        run_frame(8'h07, 0, 8'h00, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        run_frame(8'h3C, 40, 8'h01, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        run_frame(8'h96, 40, 8'h01, 1'b0, 1'b1);
        clear_overrun();
        run_frame(8'h5A, 20, 8'h05, 1'b0, 1'b1);
        clear_overrun();

        run_frame(8'hC3, 0, 8'h00, 1'b0, 1'b0);
        run_frame(8'h81, 0, 8'h00, 1'b0, 1'b0);
        check("count_after_back_to_back", int'(cnt), exp_cnt % 16);

        while (exp_cnt < 16) begin
            run_frame(8'(exp_cnt * 37), 0, 8'h00, 1'b0, 1'b0);
            @(negedge clk);
        end
        check("count_wrap", int'(cnt), 0);

        bus.ena    = 1'b0;
        bus.uio_in = 8'h01;
        @(negedge clk);
        bus.uio_in = 8'h00;
        busy_n = 0;
        repeat (40) begin
            @(negedge clk);
            busy_n += int'(busy);
        end
        check("ena_low_no_frame", busy_n, 0);
        check("ena_low_no_overrun", int'(ovr), 0);
        bus.ena = 1'b1;
        @(negedge clk);

        // Reset while in DATA aborts the frame immediately.
        bus.ui_in  = 8'h00;
        bus.uio_in = 8'h01;
        @(negedge clk);
        bus.uio_in = 8'h00;
        repeat (49) @(negedge clk);
        check("mid_data_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("mid_data_reset_txd", int'(txd), 1);
        check("mid_data_reset_busy", int'(busy), 0);
        check("mid_data_reset_cnt", int'(cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        busy_n = 0;
        done_n = 0;
        repeat (200) begin
            @(negedge clk);
            busy_n += int'(busy);
            done_n += int'(done);
        end
        check("after_abort_busy", busy_n, 0);
        check("after_abort_done", done_n, 0);
        check("after_abort_cnt", int'(cnt), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
